brick_sequencer: RTL and testbench

BRICK_SEQUENCER -- requirements
Module: brick_sequencer

---
 rtl/brick_seq_pkg.sv | 34 +++
 rtl/brick_slice_sel.sv | 18 +
 rtl/brick_sequencer.sv | 150 +++++++++++++++
 tb/tb_brick_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/brick_seq_pkg.sv
// Shared types and helpers for the bit-serial brick multiplier sequencer.
// Precision codes, FSM states, result width and slice-count/mask helpers.
package brick_seq_pkg;

  localparam int RESULT_W = 18;

  localparam int unsigned PREC_2B = 0;
  localparam int unsigned PREC_4B = 1;
  localparam int unsigned PREC_8B = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of 2-bit slices for a precision code; any code above 4b means 8b.
  function automatic logic [2:0] prec_slices(input int unsigned code);
    case (code)
      PREC_2B: return 3'd1;
      PREC_4B: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] slice_mask(input logic [2:0] n_slices);
    case (n_slices)
      3'd1:    return 8'h03;
      3'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/brick_slice_sel.sv
// Picks one 2-bit slice of an operand and flags it as signed when it is the
// most significant active slice of a two's-complement operand.
module brick_slice_sel (
  input  logic [7:0] operand,
  input  logic [1:0] idx,
  input  logic [2:0] n_slices,
  input  logic       is_signed,
  input  logic       active,
  output logic [1:0] slice,
  output logic       sgn,
  output logic       last
);

  assign last  = ({1'b0, idx} == (n_slices - 3'd1));
  assign slice = active ? operand[{idx, 1'b0} +: 2] : 2'b00;
  assign sgn   = active && is_signed && last;

endmodule

// File: rtl/brick_sequencer.sv
// Multi-precision multiplier that walks 2-bit slices through an external bitbrick.
// Optional: define BRICK_SEQ_ZERO_SKIP_EN to bypass the walk for zero operands.
module brick_sequencer
  import brick_seq_pkg::*;
#(
  parameter int PREC_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 a,
  input  logic [7:0]                 b,
  input  logic                       a_signed,
  input  logic                       b_signed,
  input  logic [PREC_W-1:0]          prec_a,
  input  logic [PREC_W-1:0]          prec_b,
  output logic [1:0]                 bb_x,
  output logic [1:0]                 bb_y,
  output logic                       bb_s_x,
  output logic                       bb_s_y,
  output logic [2:0]                 bb_shift,
  input  logic [9:0]                 bb_prod,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [RESULT_W-1:0] result
);

  state_e                     state, state_next;
  logic [7:0]                 a_r, b_r;
  logic                       a_sgn_r, b_sgn_r;
  logic [2:0]                 na_r, nb_r;
  logic [1:0]                 i_cnt, j_cnt;
  logic signed [RESULT_W-1:0] acc;

  logic [2:0]                 na_in, nb_in;
  logic                       busy, accept, zero_skip;
  logic                       last_a, last_b, last_step;
  logic [3:0]                 shift_amt;
  logic [RESULT_W-1:0]        term;
  logic signed [RESULT_W-1:0] acc_next;

  assign na_in  = prec_slices(32'(prec_a));
  assign nb_in  = prec_slices(32'(prec_b));
  assign busy   = (state == BUSY);
  assign accept = in_valid && in_ready;

`ifdef BRICK_SEQ_ZERO_SKIP_EN
  assign zero_skip = ((a & slice_mask(na_in)) == 8'h00) || ((b & slice_mask(nb_in)) == 8'h00);
`else
  assign zero_skip = 1'b0;
`endif

  brick_slice_sel u_sel_a (
    .operand   (a_r),
    .idx       (i_cnt),
    .n_slices  (na_r),
    .is_signed (a_sgn_r),
    .active    (busy),
    .slice     (bb_x),
    .sgn       (bb_s_x),
    .last      (last_a)
  );

  brick_slice_sel u_sel_b (
    .operand   (b_r),
    .idx       (j_cnt),
    .n_slices  (nb_r),
    .is_signed (b_sgn_r),
    .active    (busy),
    .slice     (bb_y),
    .sgn       (bb_s_y),
    .last      (last_b)
  );

  assign bb_shift  = 3'd0;
  assign last_step = last_a && last_b;

  // Partial product weight is 4^(i+j); sign-extend the bitbrick output first.
  assign shift_amt = {({1'b0, i_cnt} + {1'b0, j_cnt}), 1'b0};
  assign term      = {{(RESULT_W-10){bb_prod[9]}}, bb_prod} << shift_amt;
  assign acc_next  = acc + signed'(term);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment before the case keeps this block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = zero_skip ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath flop is reset so an abandoned operation leaves no
  // partial product or stale operand behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      a_sgn_r <= 1'b0;
      b_sgn_r <= 1'b0;
      na_r    <= 3'd1;
      nb_r    <= 3'd1;
      i_cnt   <= '0;
      j_cnt   <= '0;
      acc     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            a_sgn_r <= a_signed;
            b_sgn_r <= b_signed;
            na_r    <= na_in;
            nb_r    <= nb_in;
            i_cnt   <= '0;
            j_cnt   <= '0;
            acc     <= '0;
            if (zero_skip) result <= '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          if (last_a) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + 2'd1;
          end else begin
            i_cnt <= i_cnt + 2'd1;
          end
          if (last_step) result <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_sequencer.sv
// Self-checking bench for brick_sequencer: closes the loop with a 2x2 bitbrick
// model, runs a vector table through a result scoreboard, plus corner sequences.
module tb_brick_sequencer;

  localparam int PREC_W = 2;
`ifdef BRICK_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  logic [7:0]        a, b;
  logic              a_signed, b_signed;
  logic [PREC_W-1:0] prec_a, prec_b;
  logic [1:0]        bb_x, bb_y;
  logic              bb_s_x, bb_s_y;
  logic [2:0]        bb_shift;
  logic [9:0]        bb_prod;
  logic              out_valid, out_ready;
  logic signed [17:0] result;

  brick_sequencer #(.PREC_W(PREC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .prec_a    (prec_a),
    .prec_b    (prec_b),
    .bb_x      (bb_x),
    .bb_y      (bb_y),
    .bb_s_x    (bb_s_x),
    .bb_s_y    (bb_s_y),
    .bb_shift  (bb_shift),
    .bb_prod   (bb_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bitbrick: 2b x 2b multiply, each slice signed when its flag is set.
  logic signed [9:0] bx_w, by_w;
  assign bx_w    = {{8{bb_s_x & bb_x[1]}}, bb_x};
  assign by_w    = {{8{bb_s_y & bb_y[1]}}, bb_y};
  assign bb_prod = bx_w * by_w;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       a_sgn;
    logic       b_sgn;
    logic [1:0] pa;
    logic [1:0] pb;
    int         exp_res;
    int         exp_n;
    string      name;
  } vec_t;

  vec_t vecs[9];
  int   exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic sa,
                              input logic sb, input logic [1:0] pa, input logic [1:0] pb,
                              input int res, input int n, input string name);
    vec_t v;
    v.a = va; v.b = vb; v.a_sgn = sa; v.b_sgn = sb; v.pa = pa; v.pb = pb;
    v.exp_res = res; v.exp_n = n; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  task automatic drive_accept(input logic [7:0] va, input logic [7:0] vb, input logic sa,
                              input logic sb, input logic [1:0] pa, input logic [1:0] pb);
    @(negedge clk);
    check("ready_before_accept", int'(in_ready), 1);
    a = va; b = vb; a_signed = sa; b_signed = sb; prec_a = pa; prec_b = pb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; flags any in_ready on the way.
  task automatic wait_done(output int cycles, output int ready_low);
    cycles    = 0;
    ready_low = 1;
    while (!out_valid && cycles < 40) begin
      if (in_ready) ready_low = 0;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (in_ready) ready_low = 0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_handshake", int'(in_ready), 1);
    check("valid_drop_after_handshake", int'(out_valid), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, rlow, exp;
    drive_accept(v.a, v.b, v.a_sgn, v.b_sgn, v.pa, v.pb);
    exp_q.push_back(v.exp_res);
    wait_done(cyc, rlow);
    check({v.name, "_latency"}, cyc, v.exp_n);
    check({v.name, "_ready_low"}, rlow, 1);
    exp = exp_q.pop_front();
    check({v.name, "_result"}, int'(result), exp);
    release_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rlow, exp;

    vecs[0] = mk(8'h03, 8'h02, 1'b1, 1'b1, 2'b00, 2'b00,      2,  1, "s2x2");
    vecs[1] = mk(8'h80, 8'h7F, 1'b1, 1'b1, 2'b10, 2'b10, -16256, 16, "s8x8");
    vecs[2] = mk(8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 2'b10,  65025, 16, "u8x8");
    vecs[3] = mk(8'h09, 8'hC8, 1'b1, 1'b0, 2'b01, 2'b10,  -1400,  8, "s4xu8");
    vecs[4] = mk(8'hF5, 8'h3C, 1'b0, 1'b0, 2'b01, 2'b01,     60,  4, "u4x4_masked");
    vecs[5] = mk(8'h03, 8'h81, 1'b0, 1'b1, 2'b00, 2'b10,   -381,  4, "u2xs8");
    vecs[6] = mk(8'hFE, 8'h03, 1'b1, 1'b0, 2'b11, 2'b11,     -6, 16, "prec11");
    vecs[7] = mk(8'h40, 8'h55, 1'b0, 1'b0, 2'b00, 2'b10,      0, ZS ? 0 : 4, "zero_a");
    vecs[8] = mk(8'hA8, 8'hFD, 1'b1, 1'b1, 2'b01, 2'b00,     -8,  2, "s4xs2_masked");

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; prec_a = '0; prec_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_result", int'(result), 0);
    check("reset_bb", int'({bb_x, bb_y, bb_s_x, bb_s_y, bb_shift}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // DONE holds under back-pressure and ignores a pending in_valid.
    drive_accept(8'h12, 8'h34, 1'b0, 1'b0, 2'b10, 2'b10);
    exp_q.push_back(936);
    wait_done(cyc, rlow);
    check("hold_latency", cyc, 16);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_result", int'(result), 936);
      check("hold_valid", int'(out_valid), 1);
      check("hold_no_accept", int'(in_ready), 0);
      check("hold_bb_quiet", int'({bb_x, bb_y, bb_s_x, bb_s_y}), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    check("hold_final_result", int'(result), exp);
    release_result();
    check("result_kept_in_idle", int'(result), 936);

    // Reset in the middle of an 8x8 walk abandons it cleanly.
    drive_accept(8'h5A, 8'hA5, 1'b1, 1'b0, 2'b10, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_reset", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", int'(in_ready), 1);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_result", int'(result), 0);
    check("midreset_bb", int'({bb_x, bb_y, bb_s_x, bb_s_y}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
